// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for mix_columns_iter.
//   in / inv / in_valid / in_ready : input block, mode bit and its handshake
//   out / out_valid / out_ready    : transformed block and its handshake
// master: the side that supplies blocks and consumes results.
// slave : the transform engine.
interface mix_columns_iter_if;
    logic [127:0] in;
    logic         inv;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in, inv, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  in, inv, in_valid, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine.
// A block is accepted in IDLE. It is then transformed COLS_PER_CYCLE columns
// per BUSY cycle, so it takes N = 4/COLS_PER_CYCLE cycles. The result is
// held in DONE until the consumer takes it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport carrying in/inv/in_valid/in_ready and
//           out/out_valid/out_ready
// Column c of the state is bits [127-32c -: 32]; row 0 is the MSB byte.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic               clk,
    input logic               rst_n,
    mix_columns_iter_if.slave bus
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int         N      = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] K_LAST = 2'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   k;
    logic [127:0] work;
    logic [127:0] work_nxt;
    logic         inv_q;

    // Multiply by x in GF(2^8), reducing modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Every MixColumns coefficient fits in 4 bits, so four shift/add steps suffice.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // One column through the circulant matrix. Row r uses the base row rotated
    // right by r, so the coefficient for (r, c) is base[(c - r) mod 4].
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic mode);
        logic [3:0]  base [4];
        logic [7:0]  acc;
        logic [31:0] res;
        if (mode) begin
            base[0] = 4'hE; base[1] = 4'hB; base[2] = 4'hD; base[3] = 4'h9;
        end else begin
            base[0] = 4'h2; base[1] = 4'h3; base[2] = 4'h1; base[3] = 4'h1;
        end
        res = 32'h0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int c = 0; c < 4; c++) begin
                acc = acc ^ gmul(col[31 - 8*c -: 8], base[(c - r + 4) % 4]);
            end
            res[31 - 8*r -: 8] = acc;
        end
        return res;
    endfunction

    // Only COLS_PER_CYCLE column units exist; k selects the group they work on.
    always_comb begin
        work_nxt = work;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            work_nxt[127 - 32*(int'(k)*COLS_PER_CYCLE + j) -: 32] =
                mix_col(work[127 - 32*(int'(k)*COLS_PER_CYCLE + j) -: 32], inv_q);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = BUSY;
            BUSY:    if (k == K_LAST) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= 2'd0;
            work  <= 128'h0;
            inv_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work  <= bus.in;
                        inv_q <= bus.inv;
                        k     <= 2'd0;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    k    <= (k == K_LAST) ? 2'd0 : k + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = work;

endmodule
